naval_board_ctrl: RTL and testbench

NAVAL_BOARD_CTRL -- requirements
Module: naval_board_ctrl

---
 rtl/naval_pkg.sv | 40 ++++
 rtl/naval_scan.sv | 54 +++++
 rtl/naval_board_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_naval_board_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/naval_pkg.sv
// Shared types for the naval board controller: FSM states, mode codes, fleet layouts.
// Latency: none (types and a pure function only).
// Backpressure: none.
package naval_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PLACE  = 3'd1,
        ST_ARMED  = 3'd2,
        ST_ATTACK = 3'd3,
        ST_OVER   = 3'd4
    } state_e;

    localparam logic [1:0] MODE_IDLE   = 2'd0;
    localparam logic [1:0] MODE_PLACE  = 2'd1;
    localparam logic [1:0] MODE_ATTACK = 2'd2;
    localparam logic [1:0] MODE_HOLD   = 2'd3;

    // Layouts live on a fixed 8x8 grid, bit index = row*8 + col. Cells outside
    // the grid (or outside a smaller board) are simply never ships, so any
    // ROWS/COLS combination elaborates cleanly.
    //   0: col 0 rows 0-2, row 4 cols 2-3
    //   1: col 4 rows 0-1, row 6 cols 1-2, (3,3)
    //   2: row 0 cols 1-3, col 0 rows 5-6
    //   3: col 2 rows 2-3, (5,4)
    function automatic logic preset_cell(input logic [1:0] sel, input int r, input int c);
        logic [63:0] map;
        case (sel)
            2'd0:    map = 64'h0000_000C_0001_0101;
            2'd1:    map = 64'h0006_0000_0800_1010;
            2'd2:    map = 64'h0001_0100_0000_000E;
            default: map = 64'h0000_1000_0404_0000;
        endcase
        if (r < 0 || r >= 8 || c < 0 || c >= 8) begin
            return 1'b0;
        end
        return map[{r[2:0], c[2:0]}];
    endfunction

endpackage

// File: rtl/naval_scan.sv
// LED matrix column scanner: prescaler, column counter and one-hot column drive.
// Latency: m_col registered; column advances on the edge where the prescaler hits SCAN_DIV-1.
// Backpressure: none, free-running.
module naval_scan #(
    parameter int COLS     = 5,
    parameter int SCAN_DIV = 1024
) (
    input  logic                    clk,
    input  logic                    clr_n,
    output logic                    adv,
    output logic [$clog2(COLS)-1:0] col_nxt,
    output logic [COLS-1:0]         m_col
);
    import naval_pkg::*;

    localparam int          CW       = $clog2(COLS);
    localparam logic [15:0] PRE_LAST = 16'(SCAN_DIV - 1);

    logic [15:0]     pre_q, pre_d;
    logic [CW-1:0]   col_q, col_d;
    logic [COLS-1:0] m_col_q, m_col_d;
    logic            tc;

    // Prescaler terminal count steps the column; the decode uses the new index
    // so m_col and the top-level m_line refresh on the same edge.
    always_comb begin
        tc    = (pre_q == PRE_LAST);
        pre_d = tc ? 16'd0 : pre_q + 16'd1;
        col_d = col_q;
        if (tc) begin
            col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
        end
        m_col_d        = '0;
        m_col_d[col_d] = 1'b1;
    end

    // Scan state registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pre_q   <= '0;
            col_q   <= '0;
            m_col_q <= COLS'(1);
        end else begin
            pre_q   <= pre_d;
            col_q   <= col_d;
            m_col_q <= m_col_d;
        end
    end

    assign adv     = tc;
    assign col_nxt = col_d;
    assign m_col   = m_col_q;

endmodule

// File: rtl/naval_board_ctrl.sv
// Battleship-style board controller: fleet placement, shot resolution, LED matrix drive.
// Latency: hit/miss/game_over/state one cycle after confirm; m_line refreshes with each column advance.
// Backpressure: none; confirm/step pulses are acted on immediately or dropped. Build option REVEAL_EN.
module naval_board_ctrl #(
    parameter int ROWS      = 7,
    parameter int COLS      = 5,
    parameter int SHOTS_MAX = 15,
    parameter int SCAN_DIV  = 1024
) (
    input  logic                         clk,
    input  logic                         clr_n,
    input  logic [1:0]                   mode,
    input  logic [1:0]                   preset_sel,
    input  logic                         confirm,
    input  logic                         step,
    output logic [COLS-1:0]              m_col,
    output logic [ROWS-1:0]              m_line,
    output logic [$clog2(ROWS)-1:0]      cursor_row,
    output logic [$clog2(COLS)-1:0]      cursor_col,
    output logic                         hit,
    output logic                         miss,
    output logic                         game_over,
    output logic [$clog2(SHOTS_MAX+1)-1:0] shots,
    output logic [2:0]                   state
);
    import naval_pkg::*;

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int SW = $clog2(SHOTS_MAX + 1);

    // Matrices are column-major so one scanned column is a single ROWS-wide slice.
    logic [COLS-1:0][ROWS-1:0] pos_q, pos_d, atk_q, atk_d, preset_mat;
    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [SW-1:0]   shots_q, shots_d;
    logic            over_q, over_d, hit_q, hit_d, miss_q, miss_d;
    logic [ROWS-1:0] m_line_q, m_line_d, lit;
    logic [1:0]      sync_q, sync_d;
    logic            sync_ok, hold, cell_hit, shot_ok, step_ok;
    logic            scan_adv;
    logic [CW-1:0]   scan_col;

    naval_scan #(
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk     (clk),
        .clr_n   (clr_n),
        .adv     (scan_adv),
        .col_nxt (scan_col),
        .m_col   (m_col)
    );

    // Expand the selected fleet layout to the board size.
    always_comb begin
        preset_mat = '0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                preset_mat[c][r] = preset_cell(preset_sel, r, c);
            end
        end
    end

    // Two-flop release synchroniser; the FSM stays in IDLE until it reads 1.
    always_comb begin
        sync_d  = {sync_q[0], 1'b1};
        sync_ok = sync_q[1];
    end

    // Game FSM, cursor, matrices and shot bookkeeping. Mode 3 freezes everything.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        atk_d    = atk_q;
        row_d    = row_q;
        col_d    = col_q;
        shots_d  = shots_q;
        over_d   = over_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        hold     = (mode == MODE_HOLD);
        cell_hit = pos_q[col_q][row_q];
        shot_ok  = (state_q == ST_ATTACK) && confirm && !hold && !atk_q[col_q][row_q];
        step_ok  = step && !hold && ((state_q == ST_ARMED) || (state_q == ST_ATTACK));

        // Cursor walks down a column, then on to the next column, wrapping at the end.
        if (step_ok) begin
            if (row_q == RW'(ROWS - 1)) begin
                row_d = '0;
                col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
            end else begin
                row_d = row_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (mode == MODE_PLACE && sync_ok) begin
                    state_d = ST_PLACE;
                end
            end
            ST_PLACE: begin
                if (confirm && !hold) begin
                    state_d = ST_ARMED;
                    pos_d   = preset_mat;
                    atk_d   = '0;
                    shots_d = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_ARMED: begin
                if (mode == MODE_ATTACK) begin
                    state_d = ST_ATTACK;
                end
            end
            ST_ATTACK: begin
                // Shot uses the pre-step cursor; hits are a subset of ship cells,
                // so "hit count == ship count" is "no ship cell left unattacked".
                if (shot_ok) begin
                    atk_d[col_q][row_q] = 1'b1;
                    shots_d = shots_q + 1'b1;
                    hit_d   = cell_hit;
                    miss_d  = !cell_hit;
                    if ((cell_hit && ((pos_q & ~atk_d) == '0)) ||
                        (shots_d == SW'(SHOTS_MAX))) begin
                        over_d  = 1'b1;
                        state_d = ST_OVER;
                    end
                end
            end
            ST_OVER: state_d = ST_OVER;
            default: state_d = ST_IDLE;
        endcase

        // mode 0 wins from any state and wipes the game.
        if (mode == MODE_IDLE) begin
            state_d = ST_IDLE;
            pos_d   = '0;
            atk_d   = '0;
            shots_d = '0;
            over_d  = 1'b0;
            hit_d   = 1'b0;
            miss_d  = 1'b0;
        end
    end

    // Content of the column about to be scanned; 1 = LED lit (inverted onto m_line).
    always_comb begin
        lit = '0;
        case (state_q)
            ST_PLACE: lit = preset_mat[scan_col];
            ST_ARMED, ST_ATTACK: begin
                lit = pos_q[scan_col] & atk_q[scan_col];
                if (col_q == scan_col) begin
                    lit[row_q] = 1'b1;
                end
            end
            ST_OVER: begin
`ifdef REVEAL_EN
                lit = pos_q[scan_col] ^ (pos_q[scan_col] & atk_q[scan_col]);
`else
                lit = pos_q[scan_col] & atk_q[scan_col];
`endif
            end
            default: lit = '0;
        endcase
        m_line_d = scan_adv ? ~lit : m_line_q;
    end

    // All controller state.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync_q   <= '0;
            state_q  <= ST_IDLE;
            pos_q    <= '0;
            atk_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            shots_q  <= '0;
            over_q   <= 1'b0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            m_line_q <= '1;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            pos_q    <= pos_d;
            atk_q    <= atk_d;
            row_q    <= row_d;
            col_q    <= col_d;
            shots_q  <= shots_d;
            over_q   <= over_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            m_line_q <= m_line_d;
        end
    end

    assign m_line     = m_line_q;
    assign cursor_row = row_q;
    assign cursor_col = col_q;
    assign hit        = hit_q;
    assign miss       = miss_q;
    assign game_over  = over_q;
    assign shots      = shots_q;
    assign state      = state_q;

endmodule

// File: tb/tb_naval_board_ctrl.sv
// Self-checking bench for naval_board_ctrl (ROWS=7, COLS=5, SHOTS_MAX=15, SCAN_DIV=4).
// Latency: n/a.
// Backpressure: n/a.
module tb_naval_board_ctrl;
    localparam int ROWS      = 7;
    localparam int COLS      = 5;
    localparam int SHOTS_MAX = 15;
    localparam int SCAN_DIV  = 4;

    logic            clk = 1'b0;
    logic            clr_n = 1'b1;
    logic [1:0]      mode = 2'd0;
    logic [1:0]      preset_sel = 2'd0;
    logic            confirm = 1'b0;
    logic            step = 1'b0;
    logic [COLS-1:0] m_col;
    logic [ROWS-1:0] m_line;
    logic [2:0]      cursor_row, cursor_col;
    logic            hit, miss, game_over;
    logic [3:0]      shots;
    logic [2:0]      state;

    naval_board_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .SHOTS_MAX(SHOTS_MAX), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk(clk), .clr_n(clr_n), .mode(mode), .preset_sel(preset_sel),
        .confirm(confirm), .step(step), .m_col(m_col), .m_line(m_line),
        .cursor_row(cursor_row), .cursor_col(cursor_col), .hit(hit), .miss(miss),
        .game_over(game_over), .shots(shots), .state(state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { int kind; int due; } exp_t;       // kind: 1 hit, 2 miss
    exp_t sb_q[$];

    typedef struct {
        int nsteps; bit with_step; int kind;
        int shots; int row; int col; bit over;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Independent model of preset 0: col 0 rows 0-2, row 4 cols 2-3.
    function automatic bit ship0(input int r, input int c);
        return (c == 0 && r <= 2) || (r == 4 && (c == 2 || c == 3));
    endfunction

    // Pulse monitor: every hit/miss pulse must match the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (hit || miss) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, miss, hit}, 0);
            end else begin
                e = sb_q.pop_front();
                chk("pulse_kind", {30'd0, miss, hit}, e.kind);
                chk("pulse_cycle", cyc, e.due);
            end
        end
    end

    task automatic cyc_drive(input bit c, input bit s);
        confirm = c;
        step    = s;
        @(negedge clk);
        confirm = 1'b0;
        step    = 1'b0;
    endtask

    task automatic shoot(input bit s, input int kind);
        exp_t e;
        if (kind != 0) begin
            e.kind = kind;
            e.due  = cyc + 1;
            sb_q.push_back(e);
        end
        cyc_drive(1'b1, s);
    endtask

    task automatic wait_col(input int c);
        logic [COLS-1:0] want, prev;
        bit found;
        found = 1'b0;
        want  = COLS'(1) << c;
        prev  = m_col;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (m_col == want && prev != want) found = 1'b1;
            prev = m_col;
        end
        chk("scan_reach_col", 32'(found), 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int r, c, fired, guard;
        logic [ROWS-1:0] over_exp;
        //                nst  ws kind shots row col over
        tbl[0] = '{ 0, 1'b0, 1, 1, 0, 0, 1'b0};  // first shot on (0,0): hit
        tbl[1] = '{ 0, 1'b0, 0, 1, 0, 0, 1'b0};  // same cell again: ignored
        tbl[2] = '{ 1, 1'b0, 1, 2, 1, 0, 1'b0};  // (1,0) hit
        tbl[3] = '{ 1, 1'b1, 1, 3, 3, 0, 1'b0};  // (2,0) hit with step in same cycle
        tbl[4] = '{ 0, 1'b0, 2, 4, 3, 0, 1'b0};  // (3,0) miss
        tbl[5] = '{15, 1'b0, 1, 5, 4, 2, 1'b0};  // (4,2) hit
        tbl[6] = '{ 7, 1'b0, 1, 6, 4, 3, 1'b1};  // (4,3) last ship: win
        tbl[7] = '{ 1, 1'b1, 0, 6, 4, 3, 1'b1};  // OVER: step and confirm ignored
`ifdef REVEAL_EN
        over_exp = 7'h7F;
`else
        over_exp = 7'h78;
`endif

        // Reset values while held.
        #1 clr_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_m_col", m_col, 1);
        chk("rst_m_line", m_line, 7'h7F);
        chk("rst_state", state, 0);
        chk("rst_shots", shots, 0);
        chk("rst_hit_miss", {hit, miss}, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_cursor", {cursor_row, cursor_col}, 0);
        #2 clr_n = 1'b1;

        // Column scan: one column per SCAN_DIV cycles after release.
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            chk("scan_m_col", m_col, 1 << ((k / SCAN_DIV) % COLS));
        end

        // Game 1: preset 0, table-driven attack to a win.
        mode = 2'd1; preset_sel = 2'd0;
        @(negedge clk);
        chk("g1_place", state, 1);
        wait_col(0);
        chk("place_m_line_col0", m_line, 7'h78);
        cyc_drive(1'b1, 1'b0);
        chk("g1_armed", state, 2);
        mode = 2'd2;
        @(negedge clk);
        chk("g1_attack", state, 3);
        foreach (tbl[i]) begin
            repeat (tbl[i].nsteps) cyc_drive(1'b0, 1'b1);
            shoot(tbl[i].with_step, tbl[i].kind);
            chk("tbl_shots", shots, tbl[i].shots);
            chk("tbl_row", cursor_row, tbl[i].row);
            chk("tbl_col", cursor_col, tbl[i].col);
            chk("tbl_over", game_over, tbl[i].over);
            chk("tbl_state", state, tbl[i].over ? 4 : 3);
        end
        wait_col(0);
        chk("over_m_line_col0", m_line, over_exp);
        mode = 2'd0;
        @(negedge clk);
        chk("idle_state", state, 0);
        chk("idle_over_clr", game_over, 0);
        chk("idle_shots_clr", shots, 0);

        // Game 2: cursor wrap, display, then shot exhaustion on misses.
        mode = 2'd1;
        @(negedge clk);
        cyc_drive(1'b1, 1'b0);
        chk("g2_armed", state, 2);
        chk("g2_cursor_clr", {cursor_row, cursor_col}, 0);
        repeat (7) cyc_drive(1'b0, 1'b1);
        chk("step7_row", cursor_row, 0);
        chk("step7_col", cursor_col, 1);
        wait_col(1);
        chk("armed_m_line_col1", m_line, 7'h7E);
        repeat (28) cyc_drive(1'b0, 1'b1);
        chk("step35_cursor", {cursor_row, cursor_col}, 0);
        repeat (7) cyc_drive(1'b0, 1'b1);
        mode = 2'd2;
        @(negedge clk);
        chk("g2_attack", state, 3);
        r = 0; c = 1; fired = 0; guard = 0;
        while (fired < SHOTS_MAX && guard < 100) begin
            guard++;
            if (ship0(r, c)) begin
                cyc_drive(1'b0, 1'b1);
            end else begin
                fired++;
                shoot(1'b1, 2);
                chk("miss_shots", shots, fired);
                chk("miss_over", game_over, (fired == SHOTS_MAX) ? 1 : 0);
            end
            if (r == ROWS - 1) begin
                r = 0;
                c = (c == COLS - 1) ? 0 : c + 1;
            end else begin
                r++;
            end
        end
        chk("exhaust_state", state, 4);
        shoot(1'b0, 0);
        chk("shot16_ignored", shots, 15);
        chk("shot16_state", state, 4);

        // Game 3: reset in mid-attack, right after a confirm edge.
        mode = 2'd0;
        @(negedge clk);
        mode = 2'd1;
        @(negedge clk);
        cyc_drive(1'b1, 1'b0);
        mode = 2'd2;
        @(negedge clk);
        chk("g3_attack", state, 3);
        confirm = 1'b1;
        @(posedge clk);
        #1 clr_n = 1'b0;
        confirm = 1'b0;
        @(negedge clk);
        chk("midrst_pulse", {hit, miss}, 0);
        chk("midrst_shots", shots, 0);
        chk("midrst_state", state, 0);
        chk("midrst_m_col", m_col, 1);
        mode = 2'd1;
        #2 clr_n = 1'b1;
        @(negedge clk);
        chk("sync_hold_idle", state, 0);
        repeat (3) @(negedge clk);
        chk("sync_release_place", state, 1);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
